cache_line_buffer: RTL
======================

CACHE_LINE_BUFFER -- requirements
Module: cache_line_buffer

Interface
REQ-001 SHALL have parameter CACHE_SET_BITS, default 2, set index width.
REQ-002 SHALL have parameter CACHE_LINE_BITS, default 512, line width.
REQ-003 SHALL have parameter MEM_DATA_BITS, default 128, memory beat width; BEATS = CACHE_LINE_BITS/MEM_DATA_BITS, an integer >= 2.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- fill_start  in  1  begin refill of fill_set.
- fill_set  in  CACHE_SET_BITS  refill target set.
- evict_start  in  1  begin writeback of evict_set.
- evict_set  in  CACHE_SET_BITS  writeback source set.
- mem_resp_valid  in  1  refill beat present; no backpressure.
- mem_resp_data  in  MEM_DATA_BITS  refill beat.
- mem_req_data_valid  out  1  writeback beat valid.
- mem_req_data_ready  in  1  memory accepts beat.
- mem_req_data_bits  out  MEM_DATA_BITS  writeback beat.
- sram_we  out  1  line write to data SRAMs.
- sram_addr  out  CACHE_SET_BITS  SRAM set address.
- sram_din  out  CACHE_LINE_BITS  line to SRAM.
- sram_dout  in  CACHE_LINE_BITS  SRAM read data, valid one cycle after address.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- fwd_valid  out  1  refill beat forward strobe.
- fwd_idx  out  log2(BEATS)  forwarded beat index.
- fwd_data  out  MEM_DATA_BITS  forwarded beat.

Function
REQ-005 SHALL implement states IDLE, FILL, FILL_WR, EV_RD, EV_CAP, EV_SEND.
REQ-006 IDLE: if evict_start=1, SHALL latch evict_set and go to EV_RD. Else if fill_start=1, SHALL latch fill_set, clear the beat counter, and go to FILL. Evict wins if both starts are high.
REQ-007 SHALL ignore starts outside IDLE, and ignore mem_resp_valid outside FILL.
REQ-008 FILL: each mem_resp_valid cycle SHALL write mem_resp_data into line register slice [cnt*MEM_DATA_BITS +: MEM_DATA_BITS]; beat 0 is the LSBs; cnt increments.
REQ-009 On beat BEATS-1, SHALL wrap cnt to 0 and go to FILL_WR.
REQ-010 FILL_WR lasts exactly one cycle: sram_we=1, sram_din=line register; next state IDLE.
REQ-011 EV_RD lasts one cycle with sram_we=0; EV_CAP SHALL load sram_dout into the line register; next state EV_SEND.
REQ-012 EV_SEND: mem_req_data_valid=1, mem_req_data_bits=slice cnt; cnt advances only on valid&&ready; valid stays high and data stays stable while ready=0.
REQ-013 Handshake on beat BEATS-1 SHALL wrap cnt to 0 and return to IDLE.
REQ-014 done SHALL be registered, high for exactly the first IDLE cycle after FILL_WR or the final EV_SEND handshake. A start in that cycle SHALL be accepted.
REQ-015 sram_addr SHALL always equal the latched set register.
REQ-016 sram_we SHALL be 0 in every state except FILL_WR.
REQ-017 Latency: fill = final beat cycle k -> sram_we at k+1 -> done at k+2. Evict = start cycle 0 -> EV_RD 1 -> EV_CAP 2 -> first valid at 3.

Reset
REQ-018 reset=1 at a clock edge SHALL force IDLE, cnt=0, set register=0, line register=0, all outputs 0, from any state including mid-fill or mid-evict. No SRAM write and no done SHALL result from an aborted operation.

Configuration
REQ-019 Macro CACHE_LINE_BUFFER_FWD_EN defined: in FILL, each accepted beat SHALL be registered and appear the next cycle as fwd_valid=1, fwd_idx=beat index, fwd_data=beat.
REQ-020 Macro CACHE_LINE_BUFFER_FWD_EN undefined: fwd_valid, fwd_idx and fwd_data SHALL be constant 0. All other behaviour is identical.

Verification
REQ-021 Fill set 2 with beats 0x11.., 0x22.., 0x33.., 0x44.. on consecutive cycles -> sram_we=1 one cycle, sram_addr=2, sram_din={44..,33..,22..,11..}; done the next cycle.
REQ-022 Fill with idle gaps between beats (valid pattern 1,0,0,1,1,0,1) -> same line written once, after the 4th beat only.
REQ-023 Evict set 1, SRAM holding {D,C,B,A}, ready toggling 1,0,1,1,0,1 -> beats A,B,C,D in order; data held while ready=0; done after D's handshake.
REQ-024 fill_start and evict_start in the same IDLE cycle -> evict performed; fill ignored; busy high throughout.
REQ-025 reset asserted after 2 fill beats -> IDLE next cycle, sram_we never asserted; a fresh fill of 4 beats then writes only the new data.
REQ-026 With CACHE_LINE_BUFFER_FWD_EN, a 4-beat fill -> fwd_valid pulses with fwd_idx 0,1,2,3, each one cycle after its beat. Without the macro -> fwd_valid stays 0.

Source files
------------

// File: rtl/cache_line_buffer.sv
// Cache line refill/writeback buffer: assembles memory beats into a line for an SRAM write
// and streams an SRAM line out as beats. Optional refill forwarding: CACHE_LINE_BUFFER_FWD_EN.
module cache_line_buffer #(
    parameter int unsigned CACHE_SET_BITS  = 2,
    parameter int unsigned CACHE_LINE_BITS = 512,
    parameter int unsigned MEM_DATA_BITS   = 128,
    localparam int unsigned BEATS          = CACHE_LINE_BITS / MEM_DATA_BITS,
    localparam int unsigned IDX_W          = $clog2(BEATS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fill_start,
    input  logic [CACHE_SET_BITS-1:0]  fill_set,
    input  logic                       evict_start,
    input  logic [CACHE_SET_BITS-1:0]  evict_set,
    input  logic                       mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0]   mem_resp_data,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    output logic                       sram_we,
    output logic [CACHE_SET_BITS-1:0]  sram_addr,
    output logic [CACHE_LINE_BITS-1:0] sram_din,
    input  logic [CACHE_LINE_BITS-1:0] sram_dout,
    output logic                       busy,
    output logic                       done,
    output logic                       fwd_valid,
    output logic [IDX_W-1:0]           fwd_idx,
    output logic [MEM_DATA_BITS-1:0]   fwd_data
);

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        FILL_WR,
        EV_RD,
        EV_CAP,
        EV_SEND
    } state_t;

    state_t                     r_state;
    logic [IDX_W-1:0]           r_cnt;
    logic [CACHE_SET_BITS-1:0]  r_set;
    logic [CACHE_LINE_BITS-1:0] r_line;
    logic                       r_we;
    logic                       r_done;
    logic                       r_busy;
    logic                       r_req_valid;
    logic [MEM_DATA_BITS-1:0]   r_req_bits;

    logic [IDX_W-1:0] w_cnt_inc;
    logic [31:0]      w_cur_lsb;
    logic [31:0]      w_nxt_lsb;

    assign w_cnt_inc = r_cnt + IDX_W'(1);
    assign w_cur_lsb = 32'(r_cnt) * MEM_DATA_BITS;
    assign w_nxt_lsb = 32'(w_cnt_inc) * MEM_DATA_BITS;

    // Control FSM; outputs are registered alongside each transition
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_set       <= '0;
            r_line      <= '0;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_bits  <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (evict_start) begin
                        r_set   <= evict_set;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= EV_RD;
                    end else if (fill_start) begin
                        r_set   <= fill_set;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (mem_resp_valid) begin
                        r_line[w_cur_lsb +: MEM_DATA_BITS] <= mem_resp_data;
                        if (r_cnt == LAST_BEAT) begin
                            r_cnt   <= '0;
                            r_we    <= 1'b1;
                            r_state <= FILL_WR;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                FILL_WR: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                EV_RD: begin
                    r_state <= EV_CAP;
                end
                EV_CAP: begin
                    r_line      <= sram_dout;
                    r_req_bits  <= sram_dout[MEM_DATA_BITS-1:0];
                    r_req_valid <= 1'b1;
                    r_state     <= EV_SEND;
                end
                EV_SEND: begin
                    if (mem_req_data_ready) begin
                        if (r_cnt == LAST_BEAT) begin
                            r_cnt       <= '0;
                            r_req_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_cnt      <= w_cnt_inc;
                            r_req_bits <= r_line[w_nxt_lsb +: MEM_DATA_BITS];
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_data_valid = r_req_valid;
    assign mem_req_data_bits  = r_req_bits;
    assign sram_we            = r_we;
    assign sram_addr          = r_set;
    assign sram_din           = r_line;
    assign busy               = r_busy;
    assign done               = r_done;

`ifdef CACHE_LINE_BUFFER_FWD_EN
    logic                     r_fwd_valid;
    logic [IDX_W-1:0]         r_fwd_idx;
    logic [MEM_DATA_BITS-1:0] r_fwd_data;

    // Forward each accepted refill beat one cycle later for early use
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd_valid <= 1'b0;
            r_fwd_idx   <= '0;
            r_fwd_data  <= '0;
        end else begin
            r_fwd_valid <= 1'b0;
            if (r_state == FILL && mem_resp_valid) begin
                r_fwd_valid <= 1'b1;
                r_fwd_idx   <= r_cnt;
                r_fwd_data  <= mem_resp_data;
            end
        end
    end

    assign fwd_valid = r_fwd_valid;
    assign fwd_idx   = r_fwd_idx;
    assign fwd_data  = r_fwd_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_idx   = '0;
    assign fwd_data  = '0;
`endif

endmodule
